pipe_stage_reg: RTL and testbench

- Parametrised, elastic pipeline register for the 5-stage datapath; generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches into one block.
- Carries an opaque DATA_W-bit bundle between stages with a valid/ready handshake, a 2-entry skid buffer, a flush input and sticky-halt handling.
- The datapath instantiates one pipe_stage_reg per stage boundary. Each instance packs its stage's control and data fields into the bundle.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_slot.sv | 26 ++
 rtl/pipe_stage_reg.sv | 114 +++++++++++
 tb/tb_pipe_stage_reg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for the pipeline stage register
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_status_e;

   localparam int PIPE_CNT_W_DEF = 16;

   function automatic pipe_status_e slot_status(input logic main_v, input logic skid_v);
      if (skid_v)      return TWO;
      else if (main_v) return ONE;
      else             return EMPTY;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+data register; clear wins over load and leaves data untouched
module pipe_slot #(
   parameter int W = 128
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         v,
   output logic [W-1:0] q
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         v <= 1'b0;
         q <= '0;
      end else if (clear) begin
         v <= 1'b0;
      end else if (load) begin
         v <= 1'b1;
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic stage register with skid slot, flush and sticky halt
// Optional stall/bubble counters when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W   = 128,
   parameter int HALT_BIT = 0
`ifdef PIPE_STAGE_PERF_EN
   ,
   parameter int CNT_W    = PIPE_CNT_W_DEF
`endif
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              halted
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   logic              mv, sv;
   logic [DATA_W-1:0] md, sd;
   logic              main_load, main_clear, skid_load, skid_clear;
   logic [DATA_W-1:0] main_d;
   logic              acc, emit;
   pipe_status_e      status;

   assign in_ready  = !sv && !halted;
   assign out_valid = mv && !halted;
   assign out_data  = md;
   assign acc       = in_valid && in_ready;
   assign emit      = out_valid && out_ready;
   assign status    = slot_status(mv, sv);

   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      main_d     = in_data;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (status)
            EMPTY: main_load = acc;
            ONE: begin
               if (acc && emit)    main_load  = 1'b1;
               else if (acc)       skid_load  = 1'b1;
               else if (emit)      main_clear = 1'b1;
            end
            TWO: begin
               // in_ready is low here, so only a drain from skid into main can happen
               if (emit) begin
                  main_load  = 1'b1;
                  main_d     = sd;
                  skid_clear = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   pipe_slot #(.W(DATA_W)) u_main (
      .CLK   (CLK),
      .nRST  (nRST),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .v     (mv),
      .q     (md)
   );

   pipe_slot #(.W(DATA_W)) u_skid (
      .CLK   (CLK),
      .nRST  (nRST),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_data),
      .v     (sv),
      .q     (sd)
   );

   // An emit in a flush cycle still completed downstream, so it may still halt
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                     halted <= 1'b0;
      else if (emit && md[HALT_BIT]) halted <= 1'b1;
   end

`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (!out_valid && !halted && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - vector table plus scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        halted;
`ifdef PIPE_STAGE_PERF_EN
   logic [3:0]  stall_cnt;
   logic [3:0]  bubble_cnt;
`endif

   pipe_stage_reg #(
      .DATA_W   (32),
      .HALT_BIT (31)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .CNT_W    (4)
`endif
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .halted    (halted)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        exp_ov;
      logic        exp_ir;
      logic [31:0] exp_od;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] sb[$];
   logic        m_halted = 1'b0;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic pipe_status_e occ(input int n);
      if (n == 0)      return EMPTY;
      else if (n == 1) return ONE;
      else             return TWO;
   endfunction

   task automatic add_vec(input logic fl, iv, input logic [31:0] d, input logic ordy,
                          input logic eov, eir, input logic [31:0] eod);
      vec_t v;
      v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
      v.exp_ov = eov; v.exp_ir = eir; v.exp_od = eod;
      tbl.push_back(v);
   endtask

   // Called just after a falling edge; returns just after the next falling edge
   task automatic step(input logic fl, iv, input logic [31:0] d, input logic ordy);
      pipe_status_e st;
      logic         exp_ov, exp_ir, acc, emit;
      logic [31:0]  w;
      flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
      #1;
      st     = occ(sb.size());
      exp_ov = (st != EMPTY) && !m_halted;
      exp_ir = (st != TWO) && !m_halted;
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      check("in_ready",  {31'd0, in_ready},  {31'd0, exp_ir});
      check("halted",    {31'd0, halted},    {31'd0, m_halted});
      emit = exp_ov && ordy;
      acc  = iv && exp_ir;
      if (emit) begin
         w = sb.pop_front();
         check("sb_order", out_data, w);
         if (w[31]) m_halted = 1'b1;
      end
      if (fl) sb.delete();
      else if (acc) sb.push_back(d);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      nRST = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data",  out_data,           32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_halted",    {31'd0, halted},    32'd0);
      sb.delete();
      m_halted = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      // streaming
      add_vec(0, 1, 32'h11, 1, 0, 1, 32'h00);
      add_vec(0, 1, 32'h22, 1, 1, 1, 32'h11);
      add_vec(0, 1, 32'h33, 1, 1, 1, 32'h22);
      add_vec(0, 0, 32'h00, 1, 1, 1, 32'h33);
      add_vec(0, 0, 32'h00, 0, 0, 1, 32'h33);
      // backpressure into skid, then drain
      add_vec(0, 1, 32'h0A, 0, 0, 1, 32'h33);
      add_vec(0, 1, 32'h0B, 0, 1, 1, 32'h0A);
      add_vec(0, 1, 32'h0C, 0, 1, 0, 32'h0A);
      add_vec(0, 1, 32'h0C, 1, 1, 0, 32'h0A);
      add_vec(0, 1, 32'h0C, 1, 1, 1, 32'h0B);
      add_vec(0, 0, 32'h00, 1, 1, 1, 32'h0C);
      add_vec(0, 0, 32'h00, 0, 0, 1, 32'h0C);
      // flush with both slots full and a word presented
      add_vec(0, 1, 32'h05, 0, 0, 1, 32'h0C);
      add_vec(0, 1, 32'h06, 0, 1, 1, 32'h05);
      add_vec(1, 1, 32'h07, 0, 1, 0, 32'h05);
      add_vec(0, 0, 32'h00, 1, 0, 1, 32'h05);
      add_vec(0, 0, 32'h00, 1, 0, 1, 32'h05);
      // emit coinciding with flush
      add_vec(0, 1, 32'h09, 0, 0, 1, 32'h05);
      add_vec(1, 0, 32'h00, 1, 1, 1, 32'h09);
      add_vec(0, 0, 32'h00, 0, 0, 1, 32'h09);

      #1;
      do_reset();

      foreach (tbl[i]) begin
         flush = tbl[i].fl; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
         #1;
         check("vec_out_valid", {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
         check("vec_in_ready",  {31'd0, in_ready},  {31'd0, tbl[i].exp_ir});
         check("vec_out_data",  out_data,           tbl[i].exp_od);
         step(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      end
      check("sb_drained", sb.size(), 32'd0);

      // halt word emitted, stays halted through flush, cleared by reset
      step(0, 1, 32'h8000_0000, 0);
      step(0, 0, 32'h0, 1);
      step(1, 1, 32'h55, 1);
      step(0, 1, 32'h66, 1);
      do_reset();

      // halt word sitting in skid is flushed and never halts the stage
      step(0, 1, 32'h1, 0);
      step(0, 1, 32'h8000_0000, 0);
      step(1, 0, 32'h0, 0);
      step(0, 0, 32'h0, 1);
      step(0, 0, 32'h0, 1);

      // halt word emitted in a flush cycle still halts
      step(0, 1, 32'h8000_0001, 0);
      step(1, 0, 32'h0, 1);
      step(0, 0, 32'h0, 1);
      do_reset();

      // asynchronous reset mid-cycle with both slots full
      step(0, 1, 32'hA1, 0);
      step(0, 1, 32'hA2, 0);
      in_valid = 1'b0;
      @(posedge CLK);
      #2;
      nRST = 1'b0;
      #1;
      check("async_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_out_data",  out_data,           32'd0);
      check("async_in_ready",  {31'd0, in_ready},  32'd1);
      sb.delete();
      m_halted = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      step(0, 0, 32'h0, 1);

`ifdef PIPE_STAGE_PERF_EN
      nRST = 1'b0;
      #1;
      check("perf_rst_stall",  {28'd0, stall_cnt},  32'd0);
      check("perf_rst_bubble", {28'd0, bubble_cnt}, 32'd0);
      sb.delete();
      m_halted = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0);
      check("bubble_3", {28'd0, bubble_cnt}, 32'd3);
      step(0, 1, 32'h42, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 32'h0, 0);
      check("stall_sat",  {28'd0, stall_cnt},  32'd15);
      check("bubble_4",   {28'd0, bubble_cnt}, 32'd4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
